// File: rtl/fitness_pkg.sv
// State codes and width/count helpers shared by the fitness evaluator.
package fitness_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_SAMPLE   = 3'd2;
  localparam logic [2:0] ST_SAMPLE_A = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_SAMPLE_B = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam int MAX_POP_W = 32;

  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int score_width(input int n_in, input int n_out);
    return $clog2((1 << n_in) * n_out + 1);
  endfunction

  function automatic int popcount(input logic [MAX_POP_W-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < MAX_POP_W; i++) n += int'(x[i]);
    return n;
  endfunction

endpackage

// File: rtl/fitness_eval_sync_2ff.sv
// Two-flop synchroniser for the grid's asynchronous output bus; 2-cycle latency, no handshake.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fitness_eval.sv
// Scores a configured logic grid against a target truth table; done pulses 1+V*(SETTLE+1) cycles after start
// (1+V*(SETTLE+STAB_GAP+2) with FITNESS_STABILITY_EN); start is ignored while busy.
module fitness_eval
  import fitness_pkg::*;
#(
  parameter int N_IN     = 3,
  parameter int N_OUT    = 3,
  parameter int SETTLE   = 16,
  parameter int STAB_GAP = 4,
  localparam int V       = num_vec(N_IN),
  localparam int SCORE_W = score_width(N_IN, N_OUT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [V*N_OUT-1:0]   target,
  output logic [N_IN-1:0]      login,
  input  logic [N_OUT-1:0]     logout,
  output logic                 busy,
  output logic                 done,
  output logic [SCORE_W-1:0]   score,
  output logic                 perfect
);

  localparam int CNT_MAX = (SETTLE > STAB_GAP) ? SETTLE : STAB_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [2:0]         state;
  logic [V*N_OUT-1:0] tgt_q;
  logic [N_IN-1:0]    vec;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] acc_next;
  logic [N_OUT-1:0]   logout_s;
  logic [N_OUT-1:0]   tgt_bits;
  logic [N_OUT-1:0]   match_bits;

  sync_2ff #(.WIDTH(N_OUT)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (logout),
    .q     (logout_s)
  );

  assign tgt_bits = tgt_q[int'(vec)*N_OUT +: N_OUT];

`ifdef FITNESS_STABILITY_EN
  logic [N_OUT-1:0] sample_a;
  // A bit scores only if it held the target value at both sample points.
  assign match_bits = ~(sample_a ^ logout_s) & ~(logout_s ^ tgt_bits);
`else
  assign match_bits = ~(logout_s ^ tgt_bits);
`endif

  assign acc_next = acc + SCORE_W'(popcount(MAX_POP_W'(match_bits)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      tgt_q   <= '0;
      vec     <= '0;
      cnt     <= '0;
      acc     <= '0;
      login   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      score   <= '0;
      perfect <= 1'b0;
`ifdef FITNESS_STABILITY_EN
      sample_a <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tgt_q <= target;
            vec   <= '0;
            acc   <= '0;
            login <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == CNT_W'(SETTLE - 1)) begin
            cnt <= '0;
`ifdef FITNESS_STABILITY_EN
            state <= ST_SAMPLE_A;
`else
            state <= ST_SAMPLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef FITNESS_STABILITY_EN
        ST_SAMPLE_A: begin
          sample_a <= logout_s;
          cnt      <= '0;
          state    <= (STAB_GAP > 0) ? ST_HOLD : ST_SAMPLE_B;
        end
        ST_HOLD: begin
          if (cnt == CNT_W'(STAB_GAP - 1)) begin
            cnt   <= '0;
            state <= ST_SAMPLE_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: state <= ST_IDLE;
        ST_SAMPLE_B: begin
`else
        ST_SAMPLE_A, ST_HOLD, ST_SAMPLE_B: state <= ST_IDLE;
        ST_SAMPLE: begin
`endif
          acc <= acc_next;
          if (&vec) begin
            state <= ST_DONE;
          end else begin
            vec   <= vec + 1'b1;
            login <= vec + 1'b1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          score   <= acc;
          perfect <= (acc == SCORE_W'(V * N_OUT));
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_eval.sv
// Directed + randomized bench for fitness_eval with a behavioural logic_grid and truth-table scoring model.
module tb_fitness_eval;

  localparam int N_IN  = 3;
  localparam int N_OUT = 3;
  localparam int V     = 8;
  localparam int TW    = V * N_OUT;
  localparam int SETTLE = 16;
  localparam int STAB_GAP = 4;
`ifdef FITNESS_STABILITY_EN
  localparam int P = SETTLE + STAB_GAP + 2;
`else
  localparam int P = SETTLE + 1;
`endif
  localparam int LAT   = 1 + V * P;
  localparam int LIMIT = LAT + 60;

  localparam int M_PASS = 0, M_ZERO = 1, M_INV0 = 2, M_LUT = 3, M_TOG = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [TW-1:0]   target;
  logic [N_IN-1:0] login;
  logic [N_OUT-1:0] logout;
  logic            busy;
  logic            done;
  logic [4:0]      score;
  logic            perfect;

  int              mode;
  logic [N_OUT-1:0] lut [V];
  logic            tog = 1'b0;

  int passed = 0;
  int total  = 0;

  fitness_eval dut (
    .clock   (clk),
    .reset   (reset),
    .start   (start),
    .target  (target),
    .login   (login),
    .logout  (logout),
    .busy    (busy),
    .done    (done),
    .score   (score),
    .perfect (perfect)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  // Behavioural stand-in for logic_grid.
  always_comb begin
    case (mode)
      M_PASS:  logout = login;
      M_ZERO:  logout = '0;
      M_INV0:  logout = login ^ 3'b001;
      M_LUT:   logout = lut[login];
      M_TOG:   logout = {login[2:1], login[0] ^ tog};
      default: logout = login;
    endcase
  end

  function automatic logic [N_OUT-1:0] grid_fn(input int v);
    logic [N_OUT-1:0] vv;
    vv = N_OUT'(v);
    case (mode)
      M_ZERO:  return '0;
      M_INV0:  return vv ^ 3'b001;
      M_LUT:   return lut[v];
      default: return vv;
    endcase
  endfunction

  function automatic int exp_score(input logic [TW-1:0] tgt);
    int s;
    logic [N_OUT-1:0] o;
    s = 0;
    for (int v = 0; v < V; v++) begin
      o = grid_fn(v);
      for (int b = 0; b < N_OUT; b++)
        if (o[b] == tgt[v*N_OUT + b]) s++;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Called at posedge+#1; start is sampled at the very next edge.
  task automatic run_eval(input logic [TW-1:0] tgt, input bit disturb, input bit tog_mode, input string tag);
    int sc, lat, login_bad, e;
    sc = exp_score(tgt);
    lat = 0;
    login_bad = 0;
    target = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_run"}, 32'(busy), 32'(1));
    for (int j = 1; j <= LIMIT; j++) begin
      if (disturb && j == 40) begin
        start  = 1'b1;
        target = ~tgt;
      end
      if (disturb && j == 41) start = 1'b0;
      @(posedge clk); #1;
      e = j / P;
      if (e > V - 1) e = V - 1;
      if (login !== N_IN'(e)) login_bad++;
      if (done) begin
        lat = j;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_login_seq"}, 32'(login_bad), 32'(0));
    chk({tag, "_busy_done"}, 32'(busy), 32'(0));
    if (tog_mode) begin
      chk({tag, "_score_le16"}, 32'(score <= 5'd16), 32'(1));
    end else begin
      chk({tag, "_score"}, 32'(score), 32'(sc));
      chk({tag, "_perfect"}, 32'(perfect), 32'(sc == TW));
    end
  endtask

  initial begin
    logic [TW-1:0] t;
    int extra;
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    mode   = M_PASS;
    for (int i = 0; i < V; i++) lut[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_login", 32'(login), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_score", 32'(score), 32'(0));
    chk("rst_perfect", 32'(perfect), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: passthrough against identity table, then back-to-back start in the done cycle
    mode = M_PASS;
    run_eval(24'hFAC688, 1'b0, 1'b0, "t1_pass");
    run_eval(24'hFAC688, 1'b0, 1'b0, "t1_b2b");

    // 2: stuck-at-zero grid, and score hold after done
    mode = M_ZERO;
    run_eval(24'hFFFFFF, 1'b0, 1'b0, "t2_ones");
    run_eval(24'h000000, 1'b0, 1'b0, "t2_zeros");
    repeat (5) @(posedge clk);
    #1;
    chk("t2_score_hold", 32'(score), 32'(24));

    // 3: bit0 inverted
    mode = M_INV0;
    run_eval(24'hFAC688, 1'b0, 1'b0, "t3_inv0");

    // 4: reset mid-run aborts without done
    mode = M_PASS;
    target = 24'hFAC688;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy", 32'(busy), 32'(0));
    chk("t4_login", 32'(login), 32'(0));
    chk("t4_done", 32'(done), 32'(0));
    reset = 1'b0;
    extra = 0;
    for (int j = 0; j < 200; j++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("t4_no_done", 32'(extra), 32'(0));
    run_eval(24'hFAC688, 1'b0, 1'b0, "t4_fresh");

    // 5: start re-pulse and target flip mid-run
    mode = M_INV0;
    run_eval(24'hFAC688, 1'b1, 1'b0, "t5_disturb");
    extra = 0;
    for (int j = 0; j < LAT + 20; j++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("t5_single_done", 32'(extra), 32'(0));

    // Randomized grids and targets
    mode = M_LUT;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < V; i++) lut[i] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
      if (r == 0) begin
        for (int i = 0; i < V; i++) t[i*N_OUT +: N_OUT] = lut[i];
      end else begin
        t = TW'($urandom());
      end
      run_eval(t, 1'b0, 1'b0, $sformatf("rnd%0d", r));
    end

`ifdef FITNESS_STABILITY_EN
    // 6: oscillating bit0 never scores
    mode = M_TOG;
    run_eval(24'hFAC688, 1'b0, 1'b1, "t6_tog");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
